// File: rtl/bank_arb_pkg.sv
// Shared defaults, request record and id-to-onehot helper for the bank arbiter.
package bank_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ID_W    = 2;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 32;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
    logic                  we;
  } bank_req_t;

  function automatic logic [DEF_NUM_REQ-1:0] onehot(input logic [DEF_ID_W-1:0] id);
    logic [DEF_NUM_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bank_rr_arbiter_rr_pick.sv
// Rotating priority encoder: first set req scanning upward from ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    id,
  output logic               any
);

  logic [ID_W-1:0] idx;

  // ID_W-bit addition wraps naturally because NUM_REQ = 2**ID_W.
  always_comb begin
    gnt = '0;
    id  = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + ID_W'(k);
      if (!any && req[idx]) begin
        any = 1'b1;
        id  = idx;
      end
    end
    gnt[id] = any;
  end

endmodule

// File: rtl/bank_rr_arbiter.sv
// Round-robin arbiter for one shared-memory bank: pops request FIFOs, registers
// the winner toward the bank and steers read data back to its requester.
module bank_rr_arbiter
  import bank_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = DEF_ID_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RD_LAT  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]       req_we,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     bank_valid,
  input  logic                     bank_ready,
  output logic [ADDR_W-1:0]        bank_addr,
  output logic [DATA_W-1:0]        bank_wdata,
  output logic                     bank_we,
  output logic [ID_W-1:0]          bank_id,
  input  logic [DATA_W-1:0]        bank_rdata,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [DATA_W-1:0]        rsp_data
);

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    win_id;
  logic [NUM_REQ-1:0] pick_gnt;
  logic               pick_any;
  logic               accept;
  logic               grant;
  bank_req_t          sel;
  logic [RD_LAT-1:0]  rd_vld;
  logic [ID_W-1:0]    rd_id [RD_LAT];

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .id  (win_id),
    .any (pick_any)
  );

  // A grant pops the FIFO on this edge, so only grant when the stage can take it.
  assign accept = !bank_valid || bank_ready;
  assign grant  = accept && pick_any && !rst;
  assign gnt    = grant ? pick_gnt : '0;

  always_comb begin
    sel.addr  = req_addr[win_id*ADDR_W +: ADDR_W];
    sel.wdata = req_wdata[win_id*DATA_W +: DATA_W];
    sel.we    = req_we[win_id];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_valid <= 1'b0;
      bank_addr  <= '0;
      bank_wdata <= '0;
      bank_we    <= 1'b0;
      bank_id    <= '0;
      ptr        <= '0;
      rd_vld     <= '0;
      for (int i = 0; i < RD_LAT; i++) rd_id[i] <= '0;
    end else begin
      if (grant) begin
        bank_valid <= 1'b1;
        bank_addr  <= sel.addr;
        bank_wdata <= sel.wdata;
        bank_we    <= sel.we;
        bank_id    <= win_id;
        ptr        <= win_id + 1'b1;
      end else if (bank_ready) begin
        bank_valid <= 1'b0;
      end
      // Stage RD_LAT-1 lines up with the cycle the bank presents read data.
      rd_vld[0] <= bank_valid && bank_ready && !bank_we;
      rd_id[0]  <= bank_id;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_vld[i] <= rd_vld[i-1];
        rd_id[i]  <= rd_id[i-1];
      end
    end
  end

  assign rsp_valid = rd_vld[RD_LAT-1] ? onehot(rd_id[RD_LAT-1]) : '0;
  assign rsp_data  = bank_rdata;

endmodule

// File: tb/tb_bank_rr_arbiter.sv
// Directed bench for bank_rr_arbiter: arbitration order, stall, read return,
// reset and a FIFO-fed drain scenario.
module tb_bank_rr_arbiter;
  import bank_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic [3:0]  req_we = '1;
  logic [3:0]  gnt;
  logic        bank_valid;
  logic        bank_ready = 1'b1;
  logic [15:0] bank_addr;
  logic [31:0] bank_wdata;
  logic        bank_we;
  logic [1:0]  bank_id;
  logic [31:0] bank_rdata = '0;
  logic [3:0]  rsp_valid;
  logic [31:0] rsp_data;

  int vectors = 0;
  int miscompares = 0;

  bank_rr_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_we(req_we), .gnt(gnt), .bank_valid(bank_valid), .bank_ready(bank_ready),
    .bank_addr(bank_addr), .bank_wdata(bank_wdata), .bank_we(bank_we),
    .bank_id(bank_id), .bank_rdata(bank_rdata), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; bank_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*16 +: 16]  = 16'h1000 + 16'(i);
      req_wdata[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    end
    tick(); tick();
    vectors++;
    if (bank_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", bank_valid); end
    vectors++;
    if (gnt !== 4'b0000) begin miscompares++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    vectors++;
    if ({bank_id, bank_addr, bank_we} !== 19'd0) begin miscompares++; $display("FAIL reset_regs: got id %h addr %h we %b expected zeros", bank_id, bank_addr, bank_we); end
    vectors++;
    if (rsp_valid !== 4'b0000) begin miscompares++; $display("FAIL reset_rsp: got %b expected 0000", rsp_valid); end
    rst = 1'b0; req = '0;
  endtask

  task automatic test_contention();
    logic [3:0] exp_g [5];
    logic [1:0] exp_id [5];
    exp_g  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req_we = 4'b1111; req = 4'b1111; bank_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++;
      if (gnt !== exp_g[k]) begin miscompares++; $display("FAIL contention_gnt[%0d]: got %b expected %b", k, gnt, exp_g[k]); end
      tick();
      vectors++;
      if (bank_valid !== 1'b1 || bank_id !== exp_id[k] || bank_addr !== 16'h1000 + 16'(exp_id[k])) begin
        miscompares++;
        $display("FAIL contention_capture[%0d]: got v%b id %0d addr %h expected v1 id %0d addr %h",
                 k, bank_valid, bank_id, bank_addr, exp_id[k], 16'h1000 + 16'(exp_id[k]));
      end
    end
    vectors++;
    if (bank_wdata !== 32'hA000_0000) begin miscompares++; $display("FAIL contention_wdata: got %h expected a0000000", bank_wdata); end
    req = '0;
  endtask

  task automatic test_wrap();
    // ptr is 1 here; grant to 2 moves it to 3.
    req = 4'b0100; #1;
    vectors++;
    if (gnt !== 4'b0100) begin miscompares++; $display("FAIL wrap_first: got %b expected 0100", gnt); end
    tick();
    req = 4'b0100; #1;
    vectors++;
    if (gnt !== 4'b0100) begin miscompares++; $display("FAIL wrap_single: got %b expected 0100", gnt); end
    tick();
    vectors++;
    if (bank_id !== 2'd2) begin miscompares++; $display("FAIL wrap_id2: got %0d expected 2", bank_id); end
    req = 4'b0101; #1;
    vectors++;
    if (gnt !== 4'b0001) begin miscompares++; $display("FAIL wrap_scan30: got %b expected 0001", gnt); end
    tick();
    vectors++;
    if (bank_id !== 2'd0 || bank_addr !== 16'h1000) begin miscompares++; $display("FAIL wrap_id0: got id %0d addr %h expected 0 1000", bank_id, bank_addr); end
    req = '0;
  endtask

  task automatic test_stall();
    req = 4'b1111; bank_ready = 1'b1; #1;
    vectors++;
    if (gnt !== 4'b0010) begin miscompares++; $display("FAIL stall_pre_gnt: got %b expected 0010", gnt); end
    tick();
    bank_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (gnt !== 4'b0000) begin miscompares++; $display("FAIL stall_gnt[%0d]: got %b expected 0000", k, gnt); end
      vectors++;
      if (bank_valid !== 1'b1 || bank_addr !== 16'h1001) begin miscompares++; $display("FAIL stall_hold[%0d]: got v%b addr %h expected v1 1001", k, bank_valid, bank_addr); end
      tick();
    end
    bank_ready = 1'b1; #1;
    vectors++;
    if (gnt !== 4'b0100) begin miscompares++; $display("FAIL stall_release_gnt: got %b expected 0100", gnt); end
    tick();
    vectors++;
    if (bank_addr !== 16'h1002 || bank_id !== 2'd2) begin miscompares++; $display("FAIL stall_release_cap: got addr %h id %0d expected 1002 2", bank_addr, bank_id); end
    req = '0; #1;
    vectors++;
    if (gnt !== 4'b0000) begin miscompares++; $display("FAIL drain_gnt: got %b expected 0000", gnt); end
    tick();
    vectors++;
    if (bank_valid !== 1'b0) begin miscompares++; $display("FAIL drain_valid: got %b expected 0", bank_valid); end
  endtask

  task automatic test_read_return();
    req_addr[2*16 +: 16] = 16'h0040;
    req_we = 4'b1011; req = 4'b0100; bank_ready = 1'b1; #1;
    vectors++;
    if (gnt !== 4'b0100) begin miscompares++; $display("FAIL read_gnt: got %b expected 0100", gnt); end
    tick();
    vectors++;
    if (bank_valid !== 1'b1 || bank_we !== 1'b0 || bank_addr !== 16'h0040 || bank_id !== 2'd2) begin
      miscompares++;
      $display("FAIL read_cap: got v%b we%b addr %h id %0d expected v1 we0 0040 2", bank_valid, bank_we, bank_addr, bank_id);
    end
    req = '0; #1;
    vectors++;
    if (rsp_valid !== 4'b0000) begin miscompares++; $display("FAIL read_rsp_early: got %b expected 0000", rsp_valid); end
    tick();
    bank_rdata = 32'hDEAD_BEEF; #1;
    vectors++;
    if (rsp_valid !== 4'b0100) begin miscompares++; $display("FAIL read_rsp_valid: got %b expected 0100", rsp_valid); end
    vectors++;
    if (rsp_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL read_rsp_data: got %h expected deadbeef", rsp_data); end
    tick();
    bank_rdata = '0; #1;
    vectors++;
    if (rsp_valid !== 4'b0000) begin miscompares++; $display("FAIL read_rsp_once: got %b expected 0000", rsp_valid); end
    req = 4'b0010; #1;
    vectors++;
    if (gnt !== 4'b0010) begin miscompares++; $display("FAIL write_gnt: got %b expected 0010", gnt); end
    tick();
    vectors++;
    if (bank_we !== 1'b1 || bank_id !== 2'd1) begin miscompares++; $display("FAIL write_cap: got we%b id %0d expected we1 1", bank_we, bank_id); end
    req = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (rsp_valid !== 4'b0000) begin miscompares++; $display("FAIL write_no_rsp[%0d]: got %b expected 0000", k, rsp_valid); end
      tick();
    end
    req_addr[2*16 +: 16] = 16'h1002;
  endtask

  task automatic test_reset_mid();
    // ptr is 2 here.
    req_we = 4'b0000; req = 4'b0110; bank_ready = 1'b1; #1;
    vectors++;
    if (gnt !== 4'b0100) begin miscompares++; $display("FAIL rmid_gnt_a: got %b expected 0100", gnt); end
    tick(); #1;
    vectors++;
    if (gnt !== 4'b0010) begin miscompares++; $display("FAIL rmid_gnt_b: got %b expected 0010", gnt); end
    tick();
    vectors++;
    if (rsp_valid !== 4'b0100 || bank_valid !== 1'b1 || bank_id !== 2'd1) begin
      miscompares++;
      $display("FAIL rmid_inflight: got rsp %b v%b id %0d expected 0100 v1 1", rsp_valid, bank_valid, bank_id);
    end
    rst = 1'b1; #1;
    vectors++;
    if (bank_valid !== 1'b0 || gnt !== 4'b0000 || rsp_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL rmid_async: got v%b gnt %b rsp %b expected v0 0000 0000", bank_valid, gnt, rsp_valid);
    end
    tick();
    req = 4'b1111; #1;
    vectors++;
    if (gnt !== 4'b0000) begin miscompares++; $display("FAIL rmid_gnt_in_rst: got %b expected 0000", gnt); end
    rst = 1'b0; #1;
    vectors++;
    if (gnt !== 4'b0001) begin miscompares++; $display("FAIL rmid_ptr0: got %b expected 0001", gnt); end
    req = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (rsp_valid !== 4'b0000 || bank_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rmid_quiet[%0d]: got rsp %b v%b expected 0000 v0", k, rsp_valid, bank_valid);
      end
    end
  endtask

  task automatic test_fifo_drain();
    logic [15:0] mem [4][3];
    int cnt [4];
    int head [4];
    int nc;
    logic [3:0] g;
    logic [15:0] exp_addr;
    rst = 1'b1; req = '0; tick(); rst = 1'b0;
    req_we = 4'b1111; bank_ready = 1'b1; nc = 0;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 3; head[i] = 0;
      for (int j = 0; j < 3; j++) mem[i][j] = 16'h2000 + 16'(i*16 + j);
    end
    for (int c = 0; c < 40 && nc < 12; c++) begin
      for (int i = 0; i < 4; i++) begin
        req[i] = (cnt[i] != 0);
        req_addr[i*16 +: 16] = (cnt[i] != 0) ? mem[i][head[i]] : 16'h0000;
      end
      #1;
      g = gnt;
      if ((g & ~req) != 4'b0000) begin
        vectors++; miscompares++;
        $display("FAIL fifo_empty_pop: gnt %b with req %b", g, req);
      end
      tick();
      for (int i = 0; i < 4; i++) if (g[i]) begin head[i]++; cnt[i]--; end
      if (g != 4'b0000) begin
        exp_addr = 16'h2000 + 16'((nc % 4) * 16 + nc / 4);
        vectors++;
        if (bank_valid !== 1'b1 || bank_addr !== exp_addr) begin
          miscompares++;
          $display("FAIL fifo_order[%0d]: got v%b addr %h expected v1 %h", nc, bank_valid, bank_addr, exp_addr);
        end
        nc++;
      end
    end
    req = '0;
    vectors++;
    if (nc !== 12) begin miscompares++; $display("FAIL fifo_count: got %0d expected 12", nc); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (cnt[i] !== 0) begin miscompares++; $display("FAIL fifo_empty[%0d]: got %0d entries expected 0", i, cnt[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_wrap();
    test_stall();
    test_read_return();
    test_reset_mid();
    test_fifo_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
